countdown_timer: RTL and testbench

COUNTDOWN_TIMER -- requirements
Module: countdown_timer

---
 rtl/countdown_timer.sv | 103 ++++++++++
 tb/tb_countdown_timer.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/countdown_timer.sv
// countdown_timer: loadable down-counter with run/pause control.
// Q counts down by one on each CE tick while running. It stops at zero
// and then holds DONE until the next LOAD or CLR. Every output comes
// from a flop, so there is no combinational path from input to output.
// STATE carries the FSM encoding so that checkers can bind to it.
module countdown_timer #(
  parameter int BITS_NUM = 14,
  parameter int MAX_VAL  = 9999
) (
  input  logic                CLK,
  input  logic                CLR,
  input  logic                CE,
  input  logic                LOAD,
  input  logic [BITS_NUM-1:0] LOAD_VAL,
  input  logic                START,
  input  logic                STOP,
  output logic [BITS_NUM-1:0] Q,
  output logic                RUN,
  output logic                DONE,
  output logic                DONE_P,
  output logic [1:0]          STATE
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [BITS_NUM-1:0] MAX_Q = BITS_NUM'(MAX_VAL);
  localparam logic [BITS_NUM-1:0] ONE_Q = BITS_NUM'(1);

  state_t              state;
  logic [BITS_NUM-1:0] load_sat;

  // Clamp the preset value to the largest count that may be loaded.
  always_comb begin
    load_sat = LOAD_VAL;
    if (LOAD_VAL > MAX_Q) load_sat = MAX_Q;
  end

  // Drive the FSM, the counter and the registered status flags together.
  // RUN and DONE are assigned on every state change, so they always match the state.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state  <= S_IDLE;
      Q      <= '0;
      RUN    <= 1'b0;
      DONE   <= 1'b0;
      DONE_P <= 1'b0;
    end else begin
      DONE_P <= 1'b0;
      if (LOAD) begin
        // LOAD overrides CE, START and STOP in every state.
        state <= S_IDLE;
        Q     <= load_sat;
        RUN   <= 1'b0;
        DONE  <= 1'b0;
      end else begin
        case (state)
          S_IDLE, S_PAUSE: begin
            // START with STOP also high, or with Q at zero, is ignored.
            if (START && !STOP && (Q != '0)) begin
              state <= S_RUN;
              RUN   <= 1'b1;
            end
          end
          S_RUN: begin
            if (STOP) begin
              // STOP wins over a CE in the same cycle, so Q is not decremented.
              state <= S_PAUSE;
              RUN   <= 1'b0;
            end else if (CE) begin
              if (Q > ONE_Q) begin
                Q <= Q - ONE_Q;
              end else begin
                // The last tick lands on zero. Q never goes below zero.
                Q      <= '0;
                state  <= S_DONE;
                RUN    <= 1'b0;
                DONE   <= 1'b1;
                DONE_P <= 1'b1;
              end
            end
          end
          S_DONE: begin
            // DONE is held. Only LOAD or CLR leaves this state.
            state <= S_DONE;
          end
          default: begin
            state <= S_IDLE;
            RUN   <= 1'b0;
            DONE  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign STATE = state;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed testbench for countdown_timer. Each task drives one scenario
// and checks its outputs against hand-computed values.
module tb_countdown_timer;

  localparam int BITS_NUM = 14;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic                CLK;
  logic                CLR;
  logic                CE;
  logic                LOAD;
  logic [BITS_NUM-1:0] LOAD_VAL;
  logic                START;
  logic                STOP;
  logic [BITS_NUM-1:0] Q;
  logic                RUN;
  logic                DONE;
  logic                DONE_P;
  logic [1:0]          STATE;

  int n_checks = 0;
  int n_fail   = 0;

  countdown_timer #(.BITS_NUM(14), .MAX_VAL(9999)) dut (
    .CLK(CLK), .CLR(CLR), .CE(CE), .LOAD(LOAD), .LOAD_VAL(LOAD_VAL),
    .START(START), .STOP(STOP), .Q(Q), .RUN(RUN), .DONE(DONE),
    .DONE_P(DONE_P), .STATE(STATE)
  );

  // Clock and reset block: 10 ns clock; CLR is driven by the tasks.
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Driver tasks: apply the inputs, then sample 1 ns after the rising edge.
  task automatic step();
    @(posedge CLK);
    #1;
    CE = 1'b0; LOAD = 1'b0; START = 1'b0; STOP = 1'b0;
  endtask

  task automatic do_load(input logic [BITS_NUM-1:0] v);
    LOAD_VAL = v; LOAD = 1'b1;
    step();
  endtask

  task automatic clr_pulse();
    #2 CLR = 1'b1;
    #2 CLR = 1'b0;
    step();
  endtask

  task automatic test_reset();
    CLR = 1'b0; CE = 1'b0; LOAD = 1'b0; LOAD_VAL = '0; START = 1'b0; STOP = 1'b0;
    #2 CLR = 1'b1;
    #1;
    n_checks++; if (Q !== 14'd0) begin n_fail++; $display("FAIL reset_q got %0d want 0", Q); end
    n_checks++; if (RUN !== 1'b0 || DONE !== 1'b0 || DONE_P !== 1'b0) begin n_fail++; $display("FAIL reset_flags got %b%b%b want 000", RUN, DONE, DONE_P); end
    n_checks++; if (STATE !== ST_IDLE) begin n_fail++; $display("FAIL reset_state got %0d want %0d", STATE, ST_IDLE); end
    #4 CLR = 1'b0;
    step();
  endtask

  task automatic test_basic_count();
    clr_pulse();
    do_load(14'd3);
    n_checks++; if (Q !== 14'd3 || STATE !== ST_IDLE) begin n_fail++; $display("FAIL basic_load got q=%0d st=%0d want 3/0", Q, STATE); end
    START = 1'b1; step();
    n_checks++; if (RUN !== 1'b1 || Q !== 14'd3) begin n_fail++; $display("FAIL basic_start got run=%b q=%0d want 1/3", RUN, Q); end
    step();
    n_checks++; if (Q !== 14'd3) begin n_fail++; $display("FAIL basic_hold_no_ce got %0d want 3", Q); end
    CE = 1'b1; step();
    n_checks++; if (Q !== 14'd2) begin n_fail++; $display("FAIL basic_ce1 got %0d want 2", Q); end
    CE = 1'b1; step();
    n_checks++; if (Q !== 14'd1 || RUN !== 1'b1) begin n_fail++; $display("FAIL basic_ce2 got q=%0d run=%b want 1/1", Q, RUN); end
    CE = 1'b1; step();
    n_checks++; if (Q !== 14'd0 || DONE !== 1'b1 || DONE_P !== 1'b1 || RUN !== 1'b0) begin n_fail++; $display("FAIL basic_done got q=%0d d=%b dp=%b run=%b want 0/1/1/0", Q, DONE, DONE_P, RUN); end
    n_checks++; if (STATE !== ST_DONE) begin n_fail++; $display("FAIL basic_done_state got %0d want %0d", STATE, ST_DONE); end
    step();
    n_checks++; if (DONE_P !== 1'b0 || DONE !== 1'b1) begin n_fail++; $display("FAIL basic_pulse_once got dp=%b d=%b want 0/1", DONE_P, DONE); end
  endtask

  task automatic test_saturate();
    do_load(14'd12000);
    n_checks++; if (Q !== 14'd9999 || STATE !== ST_IDLE || RUN !== 1'b0) begin n_fail++; $display("FAIL sat_12000 got q=%0d st=%0d run=%b want 9999/0/0", Q, STATE, RUN); end
    do_load(14'd10000);
    n_checks++; if (Q !== 14'd9999) begin n_fail++; $display("FAIL sat_10000 got %0d want 9999", Q); end
    do_load(14'd9998);
    n_checks++; if (Q !== 14'd9998) begin n_fail++; $display("FAIL sat_9998 got %0d want 9998", Q); end
  endtask

  task automatic test_stop_beats_ce();
    do_load(14'd6);
    START = 1'b1; step();
    CE = 1'b1; step();
    n_checks++; if (Q !== 14'd5) begin n_fail++; $display("FAIL stop_pre got %0d want 5", Q); end
    STOP = 1'b1; CE = 1'b1; step();
    n_checks++; if (Q !== 14'd5 || RUN !== 1'b0 || STATE !== ST_PAUSE) begin n_fail++; $display("FAIL stop_ce got q=%0d run=%b st=%0d want 5/0/2", Q, RUN, STATE); end
    CE = 1'b1; step();
    n_checks++; if (Q !== 14'd5 || STATE !== ST_PAUSE) begin n_fail++; $display("FAIL pause_ce got q=%0d st=%0d want 5/2", Q, STATE); end
    START = 1'b1; step();
    n_checks++; if (RUN !== 1'b1) begin n_fail++; $display("FAIL resume got run=%b want 1", RUN); end
    CE = 1'b1; step();
    n_checks++; if (Q !== 14'd4) begin n_fail++; $display("FAIL resume_ce got %0d want 4", Q); end
  endtask

  task automatic test_start_stop_together();
    START = 1'b1; STOP = 1'b1; CE = 1'b1; step();
    n_checks++; if (STATE !== ST_PAUSE || Q !== 14'd4) begin n_fail++; $display("FAIL both_in_run got st=%0d q=%0d want 2/4", STATE, Q); end
    START = 1'b1; STOP = 1'b1; step();
    n_checks++; if (STATE !== ST_PAUSE || RUN !== 1'b0) begin n_fail++; $display("FAIL both_in_pause got st=%0d run=%b want 2/0", STATE, RUN); end
  endtask

  task automatic test_load_priority();
    START = 1'b1; step();
    LOAD_VAL = 14'd7; LOAD = 1'b1; CE = 1'b1; START = 1'b1; step();
    n_checks++; if (Q !== 14'd7 || STATE !== ST_IDLE || RUN !== 1'b0) begin n_fail++; $display("FAIL load_prio got q=%0d st=%0d run=%b want 7/0/0", Q, STATE, RUN); end
  endtask

  task automatic test_start_at_zero();
    clr_pulse();
    START = 1'b1; CE = 1'b1; step();
    n_checks++; if (STATE !== ST_IDLE || Q !== 14'd0 || DONE !== 1'b0 || RUN !== 1'b0) begin n_fail++; $display("FAIL start_zero got st=%0d q=%0d d=%b run=%b want 0/0/0/0", STATE, Q, DONE, RUN); end
  endtask

  task automatic test_done_hold();
    do_load(14'd1);
    START = 1'b1; step();
    CE = 1'b1; step();
    n_checks++; if (DONE !== 1'b1 || DONE_P !== 1'b1 || Q !== 14'd0) begin n_fail++; $display("FAIL done_from1 got d=%b dp=%b q=%0d want 1/1/0", DONE, DONE_P, Q); end
    START = 1'b1; CE = 1'b1; step();
    START = 1'b1; STOP = 1'b1; CE = 1'b1; step();
    n_checks++; if (DONE !== 1'b1 || Q !== 14'd0 || STATE !== ST_DONE || DONE_P !== 1'b0) begin n_fail++; $display("FAIL done_hold got d=%b q=%0d st=%0d dp=%b want 1/0/3/0", DONE, Q, STATE, DONE_P); end
    do_load(14'd7);
    n_checks++; if (Q !== 14'd7 || DONE !== 1'b0 || STATE !== ST_IDLE) begin n_fail++; $display("FAIL done_reload got q=%0d d=%b st=%0d want 7/0/0", Q, DONE, STATE); end
  endtask

  task automatic test_async_clr();
    do_load(14'd42);
    START = 1'b1; step();
    n_checks++; if (RUN !== 1'b1 || Q !== 14'd42) begin n_fail++; $display("FAIL clr_pre got run=%b q=%0d want 1/42", RUN, Q); end
    #3 CLR = 1'b1;
    #1;
    n_checks++; if (Q !== 14'd0 || RUN !== 1'b0 || STATE !== ST_IDLE) begin n_fail++; $display("FAIL clr_async got q=%0d run=%b st=%0d want 0/0/0", Q, RUN, STATE); end
    LOAD_VAL = 14'd9; LOAD = 1'b1; START = 1'b1; CE = 1'b1;
    step();
    n_checks++; if (Q !== 14'd0 || STATE !== ST_IDLE) begin n_fail++; $display("FAIL clr_dominates got q=%0d st=%0d want 0/0", Q, STATE); end
    #2 CLR = 1'b0;
    START = 1'b1; CE = 1'b1; step();
    n_checks++; if (Q !== 14'd0 || STATE !== ST_IDLE || RUN !== 1'b0) begin n_fail++; $display("FAIL clr_after got q=%0d st=%0d run=%b want 0/0/0", Q, STATE, RUN); end
  endtask

  // Scenario sequence and final report.
  initial begin
    test_reset();
    test_basic_count();
    test_saturate();
    test_stop_beats_ce();
    test_start_stop_together();
    test_load_priority();
    test_start_at_zero();
    test_done_hold();
    test_async_clr();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
